module_ctrl_secded: RTL and testbench

//  Sequencer for the Hamming SECDED decode path (codifier/detector/corrector/decoder).

---
 rtl/module_ctrl_secded.sv | 223 ++++++++++++++++++++++
 tb/tb_module_ctrl_secded.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_ctrl_secded.sv
// Sequencer for the Hamming SECDED decode path: debounced capture, settle wait,
// result registering, saturating error counters and 2-digit display scan.
module module_ctrl_secded #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned REFRESH_CYCLES  = 27000,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_captura,
  input  logic             borrar_cnt,
  input  logic [7:0]       palabra_rx,
  input  logic [2:0]       sindrome,
  input  logic             error_simple,
  input  logic             error_doble,
  input  logic [3:0]       datos_out,
  output logic [7:0]       palabra_lat,
  output logic [2:0]       sindrome_reg,
  output logic [3:0]       datos_reg,
  output logic             flag_simple,
  output logic             flag_doble,
  output logic             resultado_valido,
  output logic             ocupado,
  output logic [CNT_W-1:0] cnt_simple,
  output logic [CNT_W-1:0] cnt_doble,
  output logic [1:0]       an,
  output logic             digito_sel
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RF_W-1:0]  RF_LAST = RF_W'(REFRESH_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_LAST = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURA,
    S_ESPERA,
    S_EVALUA,
    S_MUESTRA
  } state_t;

  state_t state_q, state_d;

  logic            btn_meta_q, btn_sync_q, btn_last_q;
  logic            clr_meta_q, clr_sync_q;
  logic [7:0]      pal_meta_q, pal_sync_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_lvl_q, db_lvl_d, db_lvl_prev_q;
  logic            pulso_cap;
  logic [ST_W-1:0] wait_q, wait_d;
  logic [7:0]      lat_q;
  logic [2:0]      sind_q;
  logic [3:0]      datos_q;
  logic            fs_q, fd_q;
  logic [CNT_W-1:0] cnt_sgl_q, cnt_sgl_d, cnt_dbl_q, cnt_dbl_d;
  logic [RF_W-1:0] rf_q, rf_d;
  logic            sel_q, sel_d, scan_q, scan_d;
  logic            busy, res_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      btn_last_q    <= 1'b0;
      clr_meta_q    <= 1'b0;
      clr_sync_q    <= 1'b0;
      pal_meta_q    <= '0;
      pal_sync_q    <= '0;
      db_cnt_q      <= '0;
      db_lvl_q      <= 1'b0;
      db_lvl_prev_q <= 1'b0;
    end else begin
      btn_meta_q    <= btn_captura;
      btn_sync_q    <= btn_meta_q;
      btn_last_q    <= btn_sync_q;
      clr_meta_q    <= borrar_cnt;
      clr_sync_q    <= clr_meta_q;
      pal_meta_q    <= palabra_rx;
      pal_sync_q    <= pal_meta_q;
      db_cnt_q      <= db_cnt_d;
      db_lvl_q      <= db_lvl_d;
      db_lvl_prev_q <= db_lvl_q;
    end
  end

  // Stability counter restarts on any change; level follows only once it saturates.
  always_comb begin
    db_cnt_d = db_cnt_q;
    db_lvl_d = db_lvl_q;
    if (btn_sync_q != btn_last_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_lvl_d = btn_last_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign pulso_cap = db_lvl_q & ~db_lvl_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Captures requested while busy are dropped, not queued.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    busy      = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pulso_cap) state_d = S_CAPTURA;
      end
      S_CAPTURA: begin
        busy    = 1'b1;
        wait_d  = '0;
        state_d = S_ESPERA;
      end
      S_ESPERA: begin
        busy = 1'b1;
        if (wait_q == ST_LAST) state_d = S_EVALUA;
        else                   wait_d  = wait_q + ST_W'(1);
      end
      S_EVALUA: begin
        busy    = 1'b1;
        state_d = S_MUESTRA;
      end
      S_MUESTRA: begin
        res_valid = 1'b1;
        if (pulso_cap) state_d = S_CAPTURA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q     <= '0;
      sind_q    <= '0;
      datos_q   <= '0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      cnt_sgl_q <= '0;
      cnt_dbl_q <= '0;
    end else begin
      if (state_q == S_CAPTURA) lat_q <= pal_sync_q;
      if (state_q == S_EVALUA) begin
        sind_q  <= sindrome;
        datos_q <= datos_out;
        fs_q    <= error_simple;
        fd_q    <= error_doble;
      end
      cnt_sgl_q <= cnt_sgl_d;
      cnt_dbl_q <= cnt_dbl_d;
    end
  end

  // Double error takes precedence over single; clear overrides any increment.
  always_comb begin
    cnt_sgl_d = cnt_sgl_q;
    cnt_dbl_d = cnt_dbl_q;
    if (state_q == S_EVALUA) begin
      if (error_doble) begin
        if (cnt_dbl_q != CNT_MAX) cnt_dbl_d = cnt_dbl_q + CNT_W'(1);
      end else if (error_simple) begin
        if (cnt_sgl_q != CNT_MAX) cnt_sgl_d = cnt_sgl_q + CNT_W'(1);
      end
    end
    if (clr_sync_q) begin
      cnt_sgl_d = '0;
      cnt_dbl_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q   <= '0;
      sel_q  <= 1'b0;
      scan_q <= 1'b0;
    end else begin
      rf_q   <= rf_d;
      sel_q  <= sel_d;
      scan_q <= scan_d;
    end
  end

  // Both digits stay dark until the first wrap, which enables the right digit.
  always_comb begin
    rf_d   = rf_q + RF_W'(1);
    sel_d  = sel_q;
    scan_d = scan_q;
    if (rf_q == RF_LAST) begin
      rf_d   = '0;
      scan_d = 1'b1;
      sel_d  = scan_q ? ~sel_q : 1'b0;
    end
  end

  assign palabra_lat      = lat_q;
  assign sindrome_reg     = sind_q;
  assign datos_reg        = datos_q;
  assign flag_simple      = fs_q;
  assign flag_doble       = fd_q;
  assign resultado_valido = res_valid;
  assign ocupado          = busy;
  assign cnt_simple       = cnt_sgl_q;
  assign cnt_doble        = cnt_dbl_q;
  assign digito_sel       = sel_q;
  assign an               = scan_q ? (sel_q ? 2'b01 : 2'b10) : 2'b11;

endmodule

// File: tb/tb_module_ctrl_secded.sv
// Scoreboard bench for module_ctrl_secded with a behavioural SECDED datapath model.
module tb_module_ctrl_secded;

  localparam int unsigned DB   = 4;
  localparam int unsigned RF   = 8;
  localparam int unsigned ST   = 2;
  localparam int unsigned CW   = 4;
  localparam int unsigned ST_B = 16;

  typedef struct packed {
    logic [7:0] w;
    logic [2:0] s;
    logic [3:0] d;
    logic       fs;
    logic       fd;
  } exp_t;

  // Layout: bit k-1 holds Hamming position k (1..7), bit 7 is overall parity.
  function automatic exp_t model(input logic [7:0] w);
    exp_t r;
    logic [7:0] c;
    logic p;
    int idx;
    r.w    = w;
    r.s[0] = w[0] ^ w[2] ^ w[4] ^ w[6];
    r.s[1] = w[1] ^ w[2] ^ w[5] ^ w[6];
    r.s[2] = w[3] ^ w[4] ^ w[5] ^ w[6];
    p      = ^w;
    c      = w;
    if (p && (r.s != 3'b000)) begin
      idx    = int'(r.s) - 1;
      c[idx] = ~c[idx];
    end
    r.d  = {c[6], c[5], c[4], c[2]};
    r.fs = p;
    r.fd = ~p & (r.s != 3'b000);
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0, clr = 1'b0, btn_b = 1'b0;
  logic [7:0] pal_rx = '0, pal_b = '0;

  logic [7:0] lat, lat_b;
  logic [2:0] sreg, sreg_b;
  logic [3:0] dreg, dreg_b;
  logic fs, fd, rv, ocu, dsel, fs_b, fd_b, rv_b, ocu_b, dsel_b;
  logic [CW-1:0] cs, cd, cs_b, cd_b;
  logic [1:0] an, an_b;
  exp_t dp, dp_b;

  assign dp   = model(lat);
  assign dp_b = model(lat_b);

  always #5 clk = ~clk;

  module_ctrl_secded #(.DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF), .SETTLE_CYCLES(ST), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .btn_captura(btn), .borrar_cnt(clr), .palabra_rx(pal_rx),
    .sindrome(dp.s), .error_simple(dp.fs), .error_doble(dp.fd), .datos_out(dp.d),
    .palabra_lat(lat), .sindrome_reg(sreg), .datos_reg(dreg), .flag_simple(fs), .flag_doble(fd),
    .resultado_valido(rv), .ocupado(ocu), .cnt_simple(cs), .cnt_doble(cd), .an(an), .digito_sel(dsel)
  );

  module_ctrl_secded #(.DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF), .SETTLE_CYCLES(ST_B), .CNT_W(CW)) dut_slow (
    .clk(clk), .rst(rst), .btn_captura(btn_b), .borrar_cnt(clr), .palabra_rx(pal_b),
    .sindrome(dp_b.s), .error_simple(dp_b.fs), .error_doble(dp_b.fd), .datos_out(dp_b.d),
    .palabra_lat(lat_b), .sindrome_reg(sreg_b), .datos_reg(dreg_b), .flag_simple(fs_b), .flag_doble(fd_b),
    .resultado_valido(rv_b), .ocupado(ocu_b), .cnt_simple(cs_b), .cnt_doble(cd_b), .an(an_b), .digito_sel(dsel_b)
  );

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  exp_t e;
  int cyc = 0;
  int n_cap = 0, n_rv = 0, ocu_rise = 0, ocu_fall = 0, rv_rise = 0;
  logic ocu_p = 1'b0, rv_p = 1'b0, rise_after_rv = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (ocu && !ocu_p) begin
      n_cap++;
      ocu_rise = cyc;
      rise_after_rv = rv_p;
    end
    if (!ocu && ocu_p) ocu_fall = cyc;
    if (rv && !rv_p) begin
      rv_rise = cyc;
      n_rv++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_result got word=%h want no result", lat);
      end else begin
        e = sb.pop_front();
        if ({lat, sreg, dreg, fs, fd} !== {e.w, e.s, e.d, e.fs, e.fd}) begin
          bad++;
          $display("FAIL sb_result got lat=%h s=%b d=%h fs=%b fd=%b want lat=%h s=%b d=%h fs=%b fd=%b",
                   lat, sreg, dreg, fs, fd, e.w, e.s, e.d, e.fs, e.fd);
        end
      end
    end
    ocu_p = ocu;
    rv_p  = rv;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] w, input bit push);
    pal_rx = w;
    if (push) sb.push_back(model(w));
    repeat (3) tick();
    btn = 1'b1;
    repeat (10) tick();
    btn = 1'b0;
    repeat (8) tick();
  endtask

  task automatic wait_rv(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_rv > n0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++; if ({lat, sreg, dreg, fs, fd, rv, ocu, cs, cd, dsel} !== '0) begin
      bad++; $display("FAIL reset_outputs got %h want 0", {lat, sreg, dreg, fs, fd, rv, ocu, cs, cd, dsel});
    end
    total++; if (an !== 2'b11) begin bad++; $display("FAIL reset_an got %b want 11", an); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_clean_press();
    int c0 = n_cap;
    int n0 = n_rv;
    bit ok;
    press(8'h00, 1'b1);
    wait_rv(n0, ok);
    total++; if (!ok) begin bad++; $display("FAIL clean_timeout got no result want result"); end
    total++; if (n_cap - c0 != 1) begin bad++; $display("FAIL clean_captures got %0d want 1", n_cap - c0); end
    total++; if (rv_rise - ocu_rise != 4) begin bad++; $display("FAIL clean_latency got %0d want 4", rv_rise - ocu_rise); end
    total++; if (ocu_fall - ocu_rise != 4) begin bad++; $display("FAIL clean_busy_len got %0d want 4", ocu_fall - ocu_rise); end
    total++; if (lat !== 8'h00) begin bad++; $display("FAIL clean_lat got %h want 00", lat); end
    total++; if ({fs, fd} !== 2'b00) begin bad++; $display("FAIL clean_flags got %b want 00", {fs, fd}); end
    total++; if ({cs, cd} !== '0) begin bad++; $display("FAIL clean_counters got %h/%h want 0/0", cs, cd); end
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL clean_valid_hold got %b want 1", rv); end
  endtask

  task automatic test_bounce();
    int c0 = n_cap;
    int n0 = n_rv;
    bit ok;
    pal_rx = 8'hFF;
    sb.push_back(model(8'hFF));
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      btn = (i % 2 == 0);
      repeat (2) tick();
    end
    btn = 1'b1;
    repeat (10) tick();
    wait_rv(n0, ok);
    repeat (10) tick();
    btn = 1'b0;
    repeat (20) tick();
    total++; if (!ok) begin bad++; $display("FAIL bounce_timeout got no result want result"); end
    total++; if (n_cap - c0 != 1) begin bad++; $display("FAIL bounce_captures got %0d want 1", n_cap - c0); end
    total++; if (dreg !== 4'hF) begin bad++; $display("FAIL bounce_data got %h want f", dreg); end
  endtask

  task automatic test_errors();
    int n0 = n_rv;
    bit ok;
    press(8'h10, 1'b1);
    wait_rv(n0, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got no result want result"); end
    total++; if (sreg !== 3'b101) begin bad++; $display("FAIL single_syndrome got %b want 101", sreg); end
    total++; if ({fs, fd} !== 2'b10) begin bad++; $display("FAIL single_flags got %b want 10", {fs, fd}); end
    total++; if ({cs, cd} !== {4'h1, 4'h0}) begin bad++; $display("FAIL single_counters got %h/%h want 1/0", cs, cd); end
    n0 = n_rv;
    press(8'h03, 1'b1);
    wait_rv(n0, ok);
    total++; if (!ok) begin bad++; $display("FAIL double_timeout got no result want result"); end
    total++; if ({fs, fd} !== 2'b01) begin bad++; $display("FAIL double_flags got %b want 01", {fs, fd}); end
    total++; if ({cs, cd} !== {4'h1, 4'h1}) begin bad++; $display("FAIL double_counters got %h/%h want 1/1", cs, cd); end
  endtask

  task automatic test_busy_press();
    int rises = 0;
    bit prev = 1'b0;
    bit switched = 1'b0;
    pal_b = 8'hFF;
    repeat (3) tick();
    for (int i = 0; i < 80; i++) begin
      btn_b = (i < 6) || (i >= 12 && i < 20);
      tick();
      if (ocu_b && !prev) begin
        rises++;
        if (!switched) begin
          pal_b = 8'h10;
          switched = 1'b1;
        end
      end
      prev = ocu_b;
    end
    total++; if (rises != 1) begin bad++; $display("FAIL busy_drop_captures got %0d want 1", rises); end
    total++; if (lat_b !== 8'hFF) begin bad++; $display("FAIL busy_drop_lat got %h want ff", lat_b); end
    total++; if (rv_b !== 1'b1) begin bad++; $display("FAIL busy_drop_valid got %b want 1", rv_b); end
  endtask

  task automatic test_saturation();
    int n0 = n_rv;
    bit ok;
    for (int i = 0; i < 16; i++) press(8'h01 << (i % 8), 1'b1);
    wait_rv(n0 + 15, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_timeout got %0d results want 16", n_rv - n0); end
    total++; if (cs !== 4'hF) begin bad++; $display("FAIL sat_simple got %h want f", cs); end
    total++; if (cd !== 4'h1) begin bad++; $display("FAIL sat_doble got %h want 1", cd); end
  endtask

  task automatic test_clear();
    int n0 = n_rv;
    bit ok;
    bit armed = 1'b0;
    pal_rx = 8'h10;
    sb.push_back(model(8'h10));
    repeat (3) tick();
    btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ocu && !armed) begin
        clr = 1'b1;
        armed = 1'b1;
        repeat (2) tick();
        clr = 1'b0;
      end
    end
    btn = 1'b0;
    repeat (8) tick();
    wait_rv(n0, ok);
    total++; if (!(ok && armed)) begin bad++; $display("FAIL clear_timeout got ok=%b armed=%b want 1/1", ok, armed); end
    total++; if ({cs, cd} !== '0) begin bad++; $display("FAIL clear_wins got %h/%h want 0/0", cs, cd); end
  endtask

  task automatic test_muestra_press();
    int c0 = n_cap;
    int n0 = n_rv;
    bit ok;
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL muestra_pre got %b want 1", rv); end
    press(8'h20, 1'b1);
    wait_rv(n0, ok);
    total++; if (!ok) begin bad++; $display("FAIL muestra_timeout got no result want result"); end
    total++; if (n_cap - c0 != 1) begin bad++; $display("FAIL muestra_captures got %0d want 1", n_cap - c0); end
    total++; if (rise_after_rv !== 1'b1) begin bad++; $display("FAIL muestra_direct got %b want 1", rise_after_rv); end
    total++; if (lat !== 8'h20) begin bad++; $display("FAIL muestra_lat got %h want 20", lat); end
    total++; if (sreg !== 3'b110) begin bad++; $display("FAIL muestra_syndrome got %b want 110", sreg); end
    total++; if (cs !== 4'h1) begin bad++; $display("FAIL muestra_count got %h want 1", cs); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    logic [1:0] exp_an;
    logic exp_sel;
    pal_rx = 8'hFF;
    repeat (3) tick();
    btn = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (ocu) seen = 1'b1;
    end
    tick();
    total++; if (!seen) begin bad++; $display("FAIL rstmid_timeout got no capture want capture"); end
    rst = 1'b1;
    btn = 1'b0;
    #1;
    total++; if ({lat, sreg, dreg, fs, fd, rv, ocu, cs, cd, dsel} !== '0) begin
      bad++; $display("FAIL rstmid_outputs got %h want 0", {lat, sreg, dreg, fs, fd, rv, ocu, cs, cd, dsel});
    end
    total++; if (an !== 2'b11) begin bad++; $display("FAIL rstmid_an got %b want 11", an); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k < int'(RF)) begin
        exp_an  = 2'b11;
        exp_sel = 1'b0;
      end else begin
        exp_sel = (((k - int'(RF)) / int'(RF)) % 2) == 1;
        exp_an  = exp_sel ? 2'b01 : 2'b10;
      end
      total++; if ({an, dsel} !== {exp_an, exp_sel}) begin
        bad++; $display("FAIL scan_k%0d got an=%b sel=%b want an=%b sel=%b", k, an, dsel, exp_an, exp_sel);
      end
    end
    total++; if ({ocu, rv, lat} !== '0) begin bad++; $display("FAIL rstmid_no_resume got %h want 0", {ocu, rv, lat}); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_errors();
    test_busy_press();
    test_saturation();
    test_clear();
    test_muestra_press();
    test_reset_mid();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
